// File: rtl/riscv_fetch_queue.sv
// riscv_fetch_queue: in-order instruction fetch front end.
// This block issues word fetches under a credit limit of DEPTH. It buffers
// returned words together with their PCs in a small FIFO. On a redirect it
// flushes the FIFO and discards responses that are still in flight.
// Optional build macro: FETCH_LOG_EN. When it is defined, redirect and
// discarded-response trace lines are printed.
module riscv_fetch_queue #(
  parameter logic [31:0] INITIAL_PC_ADDRESS = 32'd36,
  parameter int          DEPTH              = 4,
  parameter string       LOG_FILE           = "fetch.log"
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW+1:0] CREDIT_LIMIT = (CW+2)'(DEPTH);

  logic [31:0]   reqPc, respPc;
  logic [CW-1:0] count, outstanding, drop;
  logic [AW-1:0] headPtr, tailPtr;
  logic [31:0]   fifoData [DEPTH];
  logic [31:0]   fifoPc   [DEPTH];
  logic [CW+1:0] creditsUsed;
  logic [CW-1:0] redirectDrop;
  logic [31:0]   redirectAligned;
  logic          fifoNotEmpty, reqFire, respDrop, respKeep, deq;

  // Every entry that is buffered, in flight, or waiting to be dropped
  // holds one credit. This guarantees that each response finds a free slot.
  assign creditsUsed     = (CW+2)'(count) + (CW+2)'(outstanding) + (CW+2)'(drop);
  assign imem_req_valid  = reset && !redirect_valid && (creditsUsed < CREDIT_LIMIT);
  assign imem_req_addr   = reqPc;
  assign reqFire         = imem_req_valid && imem_req_ready;
  assign respDrop        = imem_resp_valid && (drop != '0);
  assign respKeep        = imem_resp_valid && (drop == '0) && (outstanding != '0);
  assign fifoNotEmpty    = (count != '0);
  assign inst_valid      = reset && fifoNotEmpty;
  assign deq             = inst_valid && inst_ready;
  assign inst_data       = fifoNotEmpty ? fifoData[headPtr] : '0;
  assign inst_pc         = fifoNotEmpty ? fifoPc[headPtr]   : '0;
  assign redirectAligned = redirect_pc & 32'hFFFF_FFFC;

  // On a redirect, all live in-flight fetches become stale. A response that
  // lands in the redirect cycle itself is one of them and is consumed now.
  always_comb begin
    redirectDrop = drop + outstanding;
    if (imem_resp_valid && (redirectDrop != '0))
      redirectDrop = redirectDrop - CW'(1);
  end

  // Control state: PCs, pointers and the three credit counters
  always_ff @(posedge clock) begin
    if (!reset) begin
      reqPc       <= INITIAL_PC_ADDRESS;
      respPc      <= INITIAL_PC_ADDRESS;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      headPtr     <= '0;
      tailPtr     <= '0;
    end else if (redirect_valid) begin
      reqPc       <= redirectAligned;
      respPc      <= redirectAligned;
      count       <= '0;
      outstanding <= '0;
      drop        <= redirectDrop;
      headPtr     <= '0;
      tailPtr     <= '0;
    end else begin
      if (reqFire)  reqPc   <= reqPc + 32'd4;
      if (respKeep) respPc  <= respPc + 32'd4;
      if (respKeep) tailPtr <= tailPtr + AW'(1);
      if (deq)      headPtr <= headPtr + AW'(1);
      outstanding <= outstanding + CW'(reqFire) - CW'(respKeep);
      drop        <= drop - CW'(respDrop);
      count       <= count + CW'(respKeep) - CW'(deq);
    end
  end

  // FIFO storage. It has no reset, because count alone qualifies the contents.
  always_ff @(posedge clock) begin
    if (reset && !redirect_valid && respKeep) begin
      fifoData[tailPtr] <= imem_resp_data;
      fifoPc[tailPtr]   <= respPc;
    end
  end

  // A response with nothing outstanding or pending drop is a memory protocol error
  protocolCheck: assert property (@(posedge clock) disable iff (!reset)
    imem_resp_valid |-> (outstanding != '0 || drop != '0));

`ifdef FETCH_LOG_EN
  // Trace each redirect and each response that is thrown away
  always @(posedge clock) begin
    if (reset && redirect_valid)
      $display("t=%0t:\tfetch redirect -> %h", $time, redirectAligned);
    if (reset && (redirect_valid ? (imem_resp_valid && (drop + outstanding) != '0) : respDrop))
      $display("t=%0t:\tfetch drop %h", $time, imem_resp_data);
  end
`endif

endmodule
